ps2_command_tx: RTL and testbench

- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard on the same PS2_CLK/PS2_DAT pair the receive path uses.
- Drives both lines open-drain through output-enable signals. The top level ties each pad as `oe ? 1'b0 : 1'bz`.
- Reports completion or timeout with single-cycle pulses.
- The receive path must ignore line activity while `busy` is high.

---
 rtl/ps2_command_tx.sv | 257 +++++++++++++++++++++++++
 tb/tb_ps2_command_tx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_command_tx.sv
// ---------------------------------------------------------------------------
// ps2_command_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
// over the shared PS2_CLK/PS2_DAT pair. Both lines are open-drain: the
// *_oe outputs pull the matching line low when 1, and the pads are tied as
// `oe ? 1'b0 : 1'bz` at the top level.
//
// Ports
//   clock                          system clock (50 MHz nominal)
//   resetn                         asynchronous active-low reset
//   send_command                   1-cycle request, accepted only when idle
//   command[7:0]                   byte to send, latched on accept
//   ps2_clk_in / ps2_dat_in        raw pad values (asynchronous)
//   ps2_clk_oe / ps2_dat_oe        1 pulls the matching line low
//   busy                           high whenever a transfer is in progress
//   command_was_sent               1-cycle pulse once ACKed and bus idle
//   error_communication_timed_out  1-cycle pulse on timeout or missing ACK
// ---------------------------------------------------------------------------
module ps2_command_tx #(
    parameter int unsigned INHIBIT_CYCLES     = 6000,
    parameter int unsigned START_SETUP_CYCLES = 100,
    parameter int unsigned FIRST_EDGE_TIMEOUT = 750000,
    parameter int unsigned XFER_TIMEOUT       = 100000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       send_command,
    input  logic [7:0] command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);

    // Counter is sized for the longest interval it has to measure.
    localparam int unsigned MAX_AB  = (INHIBIT_CYCLES > START_SETUP_CYCLES) ?
                                      INHIBIT_CYCLES : START_SETUP_CYCLES;
    localparam int unsigned MAX_CD  = (FIRST_EDGE_TIMEOUT > XFER_TIMEOUT) ?
                                      FIRST_EDGE_TIMEOUT : XFER_TIMEOUT;
    localparam int unsigned MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);

    // Terminal counts: a state lasting N cycles leaves when the count is N-1.
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(START_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] FIRST_LAST   = CNT_W'(FIRST_EDGE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] XFER_LAST    = CNT_W'(XFER_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_INHIBIT    = 4'd1,
        S_REQ_START  = 4'd2,
        S_WAIT_FIRST = 4'd3,
        S_SEND_BITS  = 4'd4,
        S_WAIT_ACK   = 4'd5,
        S_WAIT_IDLE  = 4'd6,
        S_DONE       = 4'd7,
        S_ERROR      = 4'd8
    } state_t;

    // PS/2 uses odd parity: the bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // Counting stops at all-ones so a stalled bus can never wrap the timer.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    logic         clk_meta_q, clk_sync_q, clk_prev_q;
    logic         dat_meta_q, dat_sync_q;
    logic         fall;

    state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]   shift_q, shift_d;
    logic [3:0]   bit_cnt_q, bit_cnt_d;
    logic         clk_oe_q, clk_oe_d;
    logic         dat_oe_q, dat_oe_d;
    logic         busy_q, busy_d;
    logic         sent_q, sent_d;
    logic         err_q, err_d;

    // Synchronise both pads; idle bus level is high, so reset to 1 to avoid
    // a phantom falling edge after reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk_in;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat_in;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign fall = clk_prev_q & ~clk_sync_q;

    // Next-state, counter, frame shifter and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = sat_inc(cnt_q);
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (send_command) begin
                    state_d   = S_INHIBIT;
                    shift_d   = {1'b1, odd_parity(command), command};
                    bit_cnt_d = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INHIBIT: begin
                if (cnt_q >= INHIBIT_LAST) begin
                    state_d = S_REQ_START;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = S_INHIBIT;
                end
            end
            S_REQ_START: begin
                if (cnt_q >= SETUP_LAST) begin
                    state_d = S_WAIT_FIRST;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = S_REQ_START;
                end
            end
            S_WAIT_FIRST: begin
                // The first device edge puts data bit 0 on the line; the
                // transfer timer starts from here.
                if (fall) begin
                    state_d = S_SEND_BITS;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q >= FIRST_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_WAIT_FIRST;
                end
            end
            S_SEND_BITS: begin
                if (cnt_q >= XFER_LAST) begin
                    state_d = S_ERROR;
                end else if (fall) begin
                    shift_d   = {1'b1, shift_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    // Ninth shift exposes the stop bit (line released).
                    if (bit_cnt_q == 4'd8) begin
                        state_d = S_WAIT_ACK;
                    end else begin
                        state_d = S_SEND_BITS;
                    end
                end else begin
                    state_d = S_SEND_BITS;
                end
            end
            S_WAIT_ACK: begin
                if (cnt_q >= XFER_LAST) begin
                    state_d = S_ERROR;
                end else if (fall) begin
                    if (dat_sync_q) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_IDLE: begin
                if (cnt_q >= XFER_LAST) begin
                    state_d = S_ERROR;
                end else if (clk_sync_q && dat_sync_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
            S_ERROR: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        // Outputs are decoded from the next state so the registered copies
        // line up exactly with the registered state.
        clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_REQ_START);
        case (state_d)
            S_REQ_START:  dat_oe_d = 1'b1;
            S_WAIT_FIRST: dat_oe_d = 1'b1;
            S_SEND_BITS:  dat_oe_d = ~shift_d[0];
            default:      dat_oe_d = 1'b0;
        endcase
        busy_d = (state_d != S_IDLE);
        sent_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERROR);
    end

    // Single state register for the transmit FSM and its outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            shift_q   <= 10'd0;
            bit_cnt_q <= 4'd0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            sent_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
            busy_q    <= busy_d;
            sent_q    <= sent_d;
            err_q     <= err_d;
        end
    end

    assign ps2_clk_oe                    = clk_oe_q;
    assign ps2_dat_oe                    = dat_oe_q;
    assign busy                          = busy_q;
    assign command_was_sent              = sent_q;
    assign error_communication_timed_out = err_q;

endmodule

// File: tb/tb_ps2_command_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_command_tx
// Scoreboard bench for ps2_command_tx. A keyboard model answers host
// requests on the open-drain bus and records the 11 bit values it samples
// (start, 8 data, parity, stop). Each request pushes the expected outcome
// (completion or error, plus the expected frame) onto a queue; a monitor
// pops and compares whenever the DUT pulses done or error.
// ---------------------------------------------------------------------------
module tb_ps2_command_tx;

    localparam int INH   = 40;
    localparam int SETUP = 8;
    localparam int FIRST = 1000;
    localparam int XFER  = 800;
    localparam int H     = 15;     // device half clock period in cycles

    localparam int M_NORMAL = 0;
    localparam int M_NOCLK  = 1;
    localparam int M_NOACK  = 2;
    localparam int M_STOP5  = 3;

    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic       send_command = 1'b0;
    logic [7:0] command = 8'd0;
    logic       ps2_clk_oe, ps2_dat_oe, busy;
    logic       cws, err;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       clk_line, dat_line;

    assign clk_line = dev_clk & ~ps2_clk_oe;
    assign dat_line = dev_dat & ~ps2_dat_oe;

    ps2_command_tx #(
        .INHIBIT_CYCLES    (INH),
        .START_SETUP_CYCLES(SETUP),
        .FIRST_EDGE_TIMEOUT(FIRST),
        .XFER_TIMEOUT      (XFER)
    ) dut (
        .clock                        (clock),
        .resetn                       (resetn),
        .send_command                 (send_command),
        .command                      (command),
        .ps2_clk_in                   (clk_line),
        .ps2_dat_in                   (dat_line),
        .ps2_clk_oe                   (ps2_clk_oe),
        .ps2_dat_oe                   (ps2_dat_oe),
        .busy                         (busy),
        .command_was_sent             (cws),
        .error_communication_timed_out(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         is_done;
        bit         chk_frame;
        logic [10:0] frame;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] cap_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dev_mode = M_NORMAL;
    int dev_edges = 0;
    bit dev_active = 1'b0;
    int release_cyc = 0;
    int edge1_cyc = 0;
    int pulse_cyc = 0;
    int t_clk_on = 0, t_dat_on = 0, t_clk_off = 0;

    // Reference frame as the keyboard sees it, bit 0 first on the wire.
    function automatic logic [10:0] ref_frame(input logic [7:0] c);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = c[i];
        f[9]  = (($countones(c) % 2) == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    // Cycle counter.
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Timestamps of host line activity for inhibit / start-setup timing.
    initial begin
        logic pc, pd;
        pc = 1'b0;
        pd = 1'b0;
        forever begin
            @(negedge clock);
            if (!pc && ps2_clk_oe) t_clk_on = cyc;
            if (!pd && ps2_dat_oe && ps2_clk_oe) t_dat_on = cyc;
            if (pc && !ps2_clk_oe) t_clk_off = cyc;
            pc = ps2_clk_oe;
            pd = ps2_dat_oe;
        end
    end

    // Keyboard model: waits for the host request, clocks the frame in,
    // samples on rising edges, then ACKs (or not) on edge 11.
    initial begin
        logic [10:0] fr;
        bit          full;
        forever begin
            @(negedge clock);
            if (resetn && !ps2_clk_oe && ps2_dat_oe) begin
                dev_active  = 1'b1;
                release_cyc = cyc;
                full        = 1'b0;
                fr          = 11'd0;
                if (dev_mode != M_NOCLK) begin
                    repeat (H) @(negedge clock);
                    fr[0] = dat_line;
                    full  = 1'b1;
                    for (int i = 1; i <= 10; i++) begin
                        if (dev_mode == M_STOP5 && i == 6) begin
                            full = 1'b0;
                            break;
                        end
                        dev_clk   = 1'b0;
                        dev_edges = i;
                        if (i == 1) edge1_cyc = cyc;
                        repeat (H) @(negedge clock);
                        dev_clk = 1'b1;
                        fr[i]   = dat_line;
                        repeat (H) @(negedge clock);
                    end
                    if (full) begin
                        cap_q.push_back(fr);
                        if (dev_mode == M_NORMAL) dev_dat = 1'b0;
                        repeat (H / 2) @(negedge clock);
                        dev_clk   = 1'b0;
                        dev_edges = 11;
                        repeat (H) @(negedge clock);
                        dev_clk = 1'b1;
                        repeat (2) @(negedge clock);
                        dev_dat = 1'b1;
                    end
                end
                while (ps2_dat_oe) @(negedge clock);
                dev_edges  = 0;
                dev_active = 1'b0;
            end
        end
    end

    // Monitor: every done/error pulse is matched against the scoreboard.
    initial begin
        exp_t        e;
        logic [10:0] f;
        forever begin
            @(negedge clock);
            if (resetn && (cws || err)) begin
                pulse_cyc = cyc;
                checks++;
                if (cws && err) begin
                    errors++;
                    $display("FAIL pulse_exclusive done=%0d err=%0d required not both", cws, err);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse done=%0d err=%0d with nothing outstanding", cws, err);
                end else begin
                    e = exp_q.pop_front();
                    if (cws !== e.is_done) begin
                        errors++;
                        $display("FAIL outcome done=%0d err=%0d required done=%0d", cws, err, e.is_done);
                    end
                    if (e.chk_frame) begin
                        checks++;
                        if (cap_q.size() == 0) begin
                            errors++;
                            $display("FAIL frame none captured required %b", e.frame);
                        end else begin
                            f = cap_q.pop_front();
                            if (f !== e.frame) begin
                                errors++;
                                $display("FAIL frame got %b required %b", f, e.frame);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    task automatic chk_range(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s got %0d required %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic pulse_send(input logic [7:0] c);
        @(negedge clock);
        command      = c;
        send_command = 1'b1;
        @(negedge clock);
        send_command = 1'b0;
        command      = 8'($urandom);
    endtask

    task automatic start_tx(input logic [7:0] c, input int mode);
        exp_t e;
        dev_mode    = mode;
        e.is_done   = (mode == M_NORMAL);
        e.chk_frame = (mode == M_NORMAL) || (mode == M_NOACK);
        e.frame     = ref_frame(c);
        exp_q.push_back(e);
        pulse_send(c);
    endtask

    task automatic finish_tx(input string name);
        int n;
        n = 0;
        while ((busy || dev_active) && n < 6000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 6000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout busy=%0d still active after %0d cycles", name, busy, n);
        end
        repeat (2) @(negedge clock);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_clk_oe"}, int'(ps2_clk_oe), 0);
        chk({name, "_dat_oe"}, int'(ps2_dat_oe), 0);
        chk({name, "_outstanding"}, exp_q.size(), 0);
    endtask

    task automatic do_tx(input logic [7:0] c, input int mode, input string name);
        start_tx(c, mode);
        finish_tx(name);
    endtask

    task automatic wait_edges(input int n);
        int k;
        k = 0;
        while (dev_edges < n && k < 3000) begin
            @(negedge clock);
            k++;
        end
        if (k >= 3000) begin
            checks++;
            errors++;
            $display("FAIL wait_edges reached %0d required %0d", dev_edges, n);
        end
    endtask

    initial begin
        #1 resetn = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_clk_oe", int'(ps2_clk_oe), 0);
        chk("rst_dat_oe", int'(ps2_dat_oe), 0);
        chk("rst_done", int'(cws), 0);
        chk("rst_err", int'(err), 0);
        resetn = 1'b1;
        repeat (5) @(negedge clock);

        do_tx(8'hED, M_NORMAL, "tx_ed");
        chk("inhibit_len", t_dat_on - t_clk_on, INH);
        chk("setup_len", t_clk_off - t_dat_on, SETUP);
        do_tx(8'hF4, M_NORMAL, "tx_f4");
        do_tx(8'h00, M_NORMAL, "tx_00");
        do_tx(8'hFF, M_NORMAL, "tx_ff");

        do_tx(8'h5A, M_NOCLK, "noclk");
        chk_range("first_timeout", pulse_cyc - release_cyc, FIRST - 2, FIRST + 2);

        do_tx(8'h3C, M_NOACK, "noack");

        do_tx(8'h96, M_STOP5, "stop5");
        chk_range("xfer_timeout", pulse_cyc - edge1_cyc, XFER, XFER + 4);
        do_tx(8'hFF, M_NORMAL, "after_err");

        // A request while busy must not disturb the byte in flight.
        start_tx(8'hA5, M_NORMAL);
        wait_edges(3);
        pulse_send(8'h3C);
        finish_tx("ignore_busy");

        for (int i = 0; i < 6; i++) begin
            do_tx(8'($urandom), M_NORMAL, "rand");
        end

        // Reset in the middle of the data bits releases everything at once.
        dev_mode = M_NORMAL;
        pulse_send(8'h81);
        wait_edges(4);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_clk_oe", int'(ps2_clk_oe), 0);
        chk("midrst_dat_oe", int'(ps2_dat_oe), 0);
        chk("midrst_busy", int'(busy), 0);
        begin
            int k;
            k = 0;
            while (dev_active && k < 3000) begin
                @(negedge clock);
                k++;
            end
        end
        cap_q.delete();
        @(negedge clock);
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        do_tx(8'h42, M_NORMAL, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
